issue_scheduler: RTL and testbench
==================================

// Module: issue_scheduler
// PURPOSE
//   Out-of-order issue queue between dispatch/rename and register_read. Holds renamed
//   disp_packet_t entries and tracks per-source readiness via writeback tag broadcast.
//   Each cycle it selects the oldest fully-ready entry and drives it into the
//   scheduler_reg_read_if (fire_valid, sched_pkt).
//   Single issue, compacting (shift) queue: entry 0 is always the oldest.
// PARAMETERS
//   DEPTH     8   queue entries (>=2)
//   WB_PORTS  2   writeback tag broadcast ports
//   PREG_W    6   physical register index width (matches backend_pkg)
// PORTS
//   clk            in   1                 clock, rising edge
//   rst            in   1                 asynchronous, active-high reset
//   flush          in   1                 mispredict flush: empty queue, kill issue
//   disp_valid     in   1                 dispatch offers a packet
//   disp_ready     out  1                 queue accepts (count < DEPTH)
//   disp_pkt       in   disp_packet_t     renamed instruction
//   disp_src1_rdy  in   1                 src1 value already in reg file at rename
//   disp_src2_rdy  in   1                 src2 value already in reg file at rename
//   wb_valid       in   WB_PORTS          writeback broadcast valid per port
//   wb_preg        in   WB_PORTS*PREG_W   writeback destination preg per port
//   fire_valid     out  1                 to sched_if: sched_pkt is a live issue
//   sched_pkt      out  disp_packet_t     to sched_if: issued packet
//   occupancy      out  $clog2(DEPTH+1)   valid entry count
// BEHAVIOUR
//   - Reset (async): all entry valid bits 0; count=0; fire_valid=0; sched_pkt='0;
//     disp_ready=1. Reset mid-operation drops all entries; no partial issue escapes.
//   - Dispatch handshake: accepted on a cycle with disp_valid && disp_ready && !flush.
//     disp_ready is based only on the registered count (no same-cycle credit from an
//     issue). The new entry is written at slot count-issue_now.
//   - Readiness at write: src_rdy = disp_srcN_rdy | (srcN_preg==0) | any wb match this
//     cycle. Same-cycle wakeup bypass is mandatory.
//   - Wakeup: each cycle, every valid entry whose srcN_preg equals wb_preg[p] with
//     wb_valid[p] sets srcN_rdy. Bits are sticky until the entry leaves.
//   - Internal wakeup: the selected entry's dst_preg also wakes consumers (when
//     alu_en=1 and instr_valid=1). This enables back-to-back issue of dependents;
//     the forwarding path in register_read supplies the value.
//   - Select: combinational priority on the lowest index with valid&src1_rdy&src2_rdy.
//     Oldest wins. At most one issue per cycle.
//   - Issue output is registered: selected in cycle N -> fire_valid=1 and
//     sched_pkt=entry in N+1. With no selection, fire_valid=0 and sched_pkt holds.
//   - Latency: dispatch at edge E (all srcs ready) -> selected E+1 -> fire_valid E+2.
//     A dependent of an instruction selected in N is selected at N+1 at the earliest.
//   - Removal: the selected entry leaves at the end of N. Younger entries shift down
//     one slot, preserving age. Dispatch and issue in the same cycle are legal.
//     count_next = count + disp_fire - issue.
//   - Full: count==DEPTH -> disp_ready=0, even if an issue occurs that cycle.
//   - Empty: no select; fire_valid=0.
//   - Flush (sync, highest priority): all valid=0, count=0, fire_valid=0 next cycle.
//     Same-cycle dispatch is dropped; any same-cycle select is killed.
//   - occupancy = registered count; it never exceeds DEPTH.
// STRUCTURE
//   - backend_pkg: disp_packet_t (opcode, dst_areg, dst_preg, src1/2_preg,
//     rob_entry_idx, imm_val, instr_valid, pc, alu_en, br_taken) and PREG_W.
//     Add iq_entry_t {valid, src1_rdy, src2_rdy, disp_packet_t pkt} to the same package.
//   - Sub-module: iq_oldest_select: DEPTH-bit request vector -> one-hot grant plus
//     index plus any_grant. Pure priority logic, unit-tested separately.
// TESTING
//   1. Reset then dispatch pkt A (preg 5,6 ready) -> fire_valid=1 two cycles later
//      with sched_pkt==A; occupancy 1->0.
//   2. A: dst 10; B: src1=10 not ready. Dispatch A, B back-to-back
//      -> B fires exactly one cycle after A (internal wakeup).
//   3. Entry waiting on preg 12; wb_valid[1]=1, wb_preg[1]=12 -> it fires 2 cycles
//      later. Dispatch with a same-cycle wb match -> treated as ready.
//   4. Fill DEPTH=8 with unready entries -> disp_ready=0, occupancy=8.
//      Wake slot 3 -> it issues; slots 4..7 shift to 3..6; disp_ready=1 next cycle.
//   5. Entries 0 and 2 both ready -> slot 0 issues first, then the old slot 2
//      (now slot 1) issues the next cycle.
//   6. flush while count=5 and dispatch asserted -> next cycle occupancy=0,
//      fire_valid=0. Async rst pulse mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared types for the out-of-order issue queue.
//   disp_packet_t : renamed instruction as produced by dispatch/rename
//   iq_entry_t    : one issue-queue slot (valid, per-source readiness, packet)
//   PREG_W        : physical register index width used by all backend blocks
package issue_scheduler_pkg;

    localparam int PREG_W = 6;
    localparam int AREG_W = 5;
    localparam int ROB_W  = 5;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [AREG_W-1:0] dst_areg;
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
        logic [ROB_W-1:0]  rob_entry_idx;
        logic [31:0]       imm_val;
        logic              instr_valid;
        logic [31:0]       pc;
        logic              alu_en;
        logic              br_taken;
    } disp_packet_t;

    typedef struct packed {
        logic         valid;
        logic         src1_rdy;
        logic         src2_rdy;
        disp_packet_t pkt;
    } iq_entry_t;

    // An entry may be selected once it holds an instruction and both operands are available.
    function automatic logic entry_ready(input iq_entry_t e);
        return e.valid & e.src1_rdy & e.src2_rdy;
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Dispatch-side handshake and issue-side (scheduler -> register_read) bus.
//   master modport : the issue queue (accepts dispatch, drives issue)
//   slave modport  : the surrounding pipeline (drives dispatch, consumes issue)
interface issue_scheduler_if;
    import issue_scheduler_pkg::*;

    logic         disp_valid;
    logic         disp_ready;
    disp_packet_t disp_pkt;
    logic         disp_src1_rdy;
    logic         disp_src2_rdy;
    logic         fire_valid;
    disp_packet_t sched_pkt;

    modport master (
        input  disp_valid, disp_pkt, disp_src1_rdy, disp_src2_rdy,
        output disp_ready, fire_valid, sched_pkt
    );

    modport slave (
        output disp_valid, disp_pkt, disp_src1_rdy, disp_src2_rdy,
        input  disp_ready, fire_valid, sched_pkt
    );
endinterface

// File: rtl/issue_scheduler_iq_oldest_select.sv
// Oldest-first select for the compacting issue queue (iq_oldest_select).
// Slot 0 is the oldest, so the lowest requesting index wins.
//   req       in  DEPTH      per-slot request (entry valid and fully ready)
//   grant     out DEPTH      one-hot grant
//   grant_idx out log2 DEPTH index of the granted slot (0 when none)
//   any_grant out 1          some slot was granted
module issue_scheduler_iq_oldest_select #(
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             any_grant
);
    logic found_s;

    // Priority chain from slot 0 upward: a slot is granted only if no older slot requested.
    always_comb begin
        grant     = {DEPTH{1'b0}};
        grant_idx = {IW{1'b0}};
        found_s   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i]  = req[i] & ~found_s;
            grant_idx = grant[i] ? IW'(i) : grant_idx;
            found_s   = found_s | req[i];
        end
        any_grant = found_s;
    end
endmodule

// File: rtl/issue_scheduler.sv
// Single-issue, compacting out-of-order issue queue.
// Entries wait for both sources via writeback tag broadcast plus the internal
// wakeup of the instruction selected this cycle; the oldest ready entry issues
// through a registered output stage.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear of the whole queue, kills same-cycle issue
//   sif        : dispatch handshake in, fire_valid/sched_pkt out
//   wb_valid   : per-port writeback broadcast valid
//   wb_preg    : per-port writeback destination preg (port p at [p*PREG_W +: PREG_W])
//   occupancy  : registered count of valid entries
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    issue_scheduler_if.master            sif,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]   wb_preg,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int CW   = $clog2(DEPTH+1);
    localparam int IW   = $clog2(DEPTH);
    localparam int NTAG = WB_PORTS + 1;   // writeback ports plus the internal wakeup tag

    iq_entry_t             entries_r [DEPTH];
    iq_entry_t             woken_s   [DEPTH];
    iq_entry_t             entries_s [DEPTH];
    iq_entry_t             new_entry_s;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_s;
    logic                  disp_ready_r;
    logic                  fire_valid_r;
    disp_packet_t          sched_pkt_r;
    logic [DEPTH-1:0]      req_s;
    logic [DEPTH-1:0]      grant_s;
    logic [IW-1:0]         grant_idx_s;
    logic                  any_grant_s;
    logic                  issue_s;
    logic                  disp_fire_s;
    logic [IW-1:0]         slot_s;
    logic [NTAG-1:0]       tag_valid_s;
    logic [NTAG*PREG_W-1:0] tag_preg_s;

    function automatic logic tag_hit(input logic [PREG_W-1:0] preg,
                                     input logic [NTAG-1:0] tv,
                                     input logic [NTAG*PREG_W-1:0] tp);
        logic h;
        h = 1'b0;
        for (int t = 0; t < NTAG; t++) begin
            h = h | (tv[t] & (tp[t*PREG_W +: PREG_W] == preg));
        end
        return h;
    endfunction

    // Request vector: selection always works on registered readiness.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            req_s[i] = entry_ready(entries_r[i]);
        end
    end

    issue_scheduler_iq_oldest_select #(.DEPTH(DEPTH), .IW(IW)) u_select (
        .req       (req_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    assign issue_s     = any_grant_s & ~flush;
    assign disp_fire_s = sif.disp_valid & disp_ready_r & ~flush;
    // New entry lands just above the survivors; an issue this cycle frees one slot below.
    assign slot_s      = IW'(count_r - CW'(issue_s));

    // Wakeup tags: external writebacks plus the selected ALU instruction's destination,
    // which lets a dependent issue back-to-back using register_read forwarding.
    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            tag_valid_s[p]                   = wb_valid[p];
            tag_preg_s[p*PREG_W +: PREG_W]   = wb_preg[p*PREG_W +: PREG_W];
        end
        tag_valid_s[WB_PORTS] = issue_s & entries_r[grant_idx_s].pkt.alu_en
                                        & entries_r[grant_idx_s].pkt.instr_valid;
        tag_preg_s[WB_PORTS*PREG_W +: PREG_W] = entries_r[grant_idx_s].pkt.dst_preg;
    end

    // Next queue image: wake, compact above the issued slot, then append the dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken_s[i]          = entries_r[i];
            woken_s[i].src1_rdy = entries_r[i].src1_rdy
                                | tag_hit(entries_r[i].pkt.src1_preg, tag_valid_s, tag_preg_s);
            woken_s[i].src2_rdy = entries_r[i].src2_rdy
                                | tag_hit(entries_r[i].pkt.src2_preg, tag_valid_s, tag_preg_s);
        end

        new_entry_s.valid    = 1'b1;
        new_entry_s.pkt      = sif.disp_pkt;
        new_entry_s.src1_rdy = sif.disp_src1_rdy | (sif.disp_pkt.src1_preg == PREG_W'(0))
                             | tag_hit(sif.disp_pkt.src1_preg, tag_valid_s, tag_preg_s);
        new_entry_s.src2_rdy = sif.disp_src2_rdy | (sif.disp_pkt.src2_preg == PREG_W'(0))
                             | tag_hit(sif.disp_pkt.src2_preg, tag_valid_s, tag_preg_s);

        for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue_s && (i >= int'(grant_idx_s))) begin
                entries_s[i] = woken_s[i+1];
            end else begin
                entries_s[i] = woken_s[i];
            end
        end
        // The top slot always empties on an issue since every index is at or below it.
        entries_s[DEPTH-1] = issue_s ? iq_entry_t'('0) : woken_s[DEPTH-1];

        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire_s && (slot_s == IW'(i))) begin
                entries_s[i] = new_entry_s;
            end else begin
                entries_s[i] = entries_s[i];
            end
        end

        count_s = count_r + CW'(disp_fire_s) - CW'(issue_s);
    end

    // Queue state, count, dispatch credit and the registered issue stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
            count_r      <= '0;
            disp_ready_r <= 1'b1;
            fire_valid_r <= 1'b0;
            sched_pkt_r  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
            count_r      <= '0;
            disp_ready_r <= 1'b1;
            fire_valid_r <= 1'b0;
        end else begin
            entries_r    <= entries_s;
            count_r      <= count_s;
            disp_ready_r <= (count_s != CW'(DEPTH));
            fire_valid_r <= issue_s;
            if (issue_s) begin
                sched_pkt_r <= entries_r[grant_idx_s].pkt;
            end else begin
                sched_pkt_r <= sched_pkt_r;
            end
        end
    end

    assign sif.disp_ready = disp_ready_r;
    assign sif.fire_valid = fire_valid_r;
    assign sif.sched_pkt  = sched_pkt_r;
    assign occupancy      = count_r;

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    localparam int DEPTH    = 8;
    localparam int WB_PORTS = 2;
    localparam int CW       = $clog2(DEPTH+1);

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic [WB_PORTS-1:0]        wb_valid;
    logic [WB_PORTS*PREG_W-1:0] wb_preg;
    logic [CW-1:0]              occupancy;

    issue_scheduler_if sif();

    issue_scheduler #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .sif       (sif),
        .wb_valid  (wb_valid),
        .wb_preg   (wb_preg),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues: expected issues and expected occupancy, tagged with the cycle due.
    typedef struct { int due; disp_packet_t pkt; } fire_exp_t;
    typedef struct { int due; int occ; } occ_exp_t;
    fire_exp_t fq[$];
    occ_exp_t  oq[$];

    // Reference model: age-ordered list of waiting instructions.
    typedef struct { disp_packet_t pkt; bit r1; bit r2; } m_t;
    m_t mq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (sif.fire_valid) begin
                n_cmp++;
                if (fq.size() == 0 || fq[0].due != cyc) begin
                    n_bad++;
                    $display("FAIL fire_unexpected: got issue pc=%0h expected no issue (cycle %0d)",
                             sif.sched_pkt.pc, cyc);
                end else begin
                    if (sif.sched_pkt !== fq[0].pkt) begin
                        n_bad++;
                        $display("FAIL sched_pkt: got %0h expected %0h (cycle %0d)",
                                 sif.sched_pkt, fq[0].pkt, cyc);
                    end
                    void'(fq.pop_front());
                end
            end else if (fq.size() != 0 && fq[0].due == cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL fire_missing: got fire_valid=0 expected issue pc=%0h (cycle %0d)",
                         fq[0].pkt.pc, cyc);
                void'(fq.pop_front());
            end
            if (oq.size() != 0 && oq[0].due == cyc) begin
                n_cmp++;
                if (occupancy !== CW'(oq[0].occ) || sif.disp_ready !== (oq[0].occ < DEPTH)) begin
                    n_bad++;
                    $display("FAIL occupancy: got occ=%0d rdy=%0b expected occ=%0d rdy=%0b (cycle %0d)",
                             occupancy, sif.disp_ready, oq[0].occ, (oq[0].occ < DEPTH), cyc);
                end
                void'(oq.pop_front());
            end
        end
    end

    function automatic bit hit(input logic [PREG_W-1:0] r, input logic [WB_PORTS-1:0] wv,
                               input logic [WB_PORTS*PREG_W-1:0] wp,
                               input bit iv, input logic [PREG_W-1:0] ip);
        if (iv && ip == r) return 1'b1;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wv[p] && wp[p*PREG_W +: PREG_W] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drive one cycle of inputs (called at a falling edge), advance the model, wait one cycle.
    task automatic step(input logic f, input logic dv, input disp_packet_t p,
                        input logic s1, input logic s2,
                        input logic [WB_PORTS-1:0] wv, input logic [WB_PORTS*PREG_W-1:0] wp);
        int sel;
        bit iv;
        bit acc;
        logic [PREG_W-1:0] ip;
        m_t ne;
        flush = f; sif.disp_valid = dv; sif.disp_pkt = p;
        sif.disp_src1_rdy = s1; sif.disp_src2_rdy = s2;
        wb_valid = wv; wb_preg = wp;
        if (f) begin
            mq.delete();
        end else begin
            sel = -1; iv = 1'b0; ip = '0;
            acc = dv && (mq.size() < DEPTH);
            foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
            if (sel >= 0) begin
                iv = mq[sel].pkt.alu_en && mq[sel].pkt.instr_valid;
                ip = mq[sel].pkt.dst_preg;
                fq.push_back('{cyc + 1, mq[sel].pkt});
                mq.delete(sel);
            end
            foreach (mq[i]) begin
                mq[i].r1 = mq[i].r1 | hit(mq[i].pkt.src1_preg, wv, wp, iv, ip);
                mq[i].r2 = mq[i].r2 | hit(mq[i].pkt.src2_preg, wv, wp, iv, ip);
            end
            if (acc) begin
                ne.pkt = p;
                ne.r1  = s1 || p.src1_preg == 0 || hit(p.src1_preg, wv, wp, iv, ip);
                ne.r2  = s2 || p.src2_preg == 0 || hit(p.src2_preg, wv, wp, iv, ip);
                mq.push_back(ne);
            end
        end
        oq.push_back('{cyc + 1, mq.size()});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic disp_packet_t mk(input int s1, input int s2, input int d, input int id);
        disp_packet_t p;
        p.opcode = 7'($urandom); p.dst_areg = 5'($urandom); p.rob_entry_idx = 5'(id);
        p.imm_val = $urandom; p.pc = 32'(id * 4); p.br_taken = 1'($urandom);
        p.src1_preg = PREG_W'(s1); p.src2_preg = PREG_W'(s2); p.dst_preg = PREG_W'(d);
        p.alu_en = 1'b1; p.instr_valid = 1'b1;
        return p;
    endfunction

    function automatic logic [WB_PORTS*PREG_W-1:0] wbp(input int p1, input int p0);
        return {PREG_W'(p1), PREG_W'(p0)};
    endfunction

    task automatic check_reset_outputs(input string nm);
        disp_packet_t zero_pkt;
        zero_pkt = '0;
        chk({nm, "_fire_valid"}, 128'(sif.fire_valid), 128'(1'b0));
        chk({nm, "_occupancy"},  128'(occupancy), 128'(0));
        chk({nm, "_disp_ready"}, 128'(sif.disp_ready), 128'(1'b1));
        chk({nm, "_sched_pkt"},  128'(sif.sched_pkt), 128'(zero_pkt));
    endtask

    task automatic mid_reset();
        flush = 1'b0; sif.disp_valid = 1'b0; wb_valid = '0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        mq.delete(); fq.delete(); oq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        disp_packet_t p;
        rst = 1'b1; flush = 1'b0; sif.disp_valid = 1'b0; sif.disp_pkt = '0;
        sif.disp_src1_rdy = 1'b0; sif.disp_src2_rdy = 1'b0; wb_valid = '0; wb_preg = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single ready packet.
        step(1'b0, 1'b1, mk(5, 6, 7, 1), 1'b1, 1'b1, '0, '0);
        idle(3);
        // Back-to-back dependent via internal wakeup.
        step(1'b0, 1'b1, mk(1, 2, 10, 2), 1'b1, 1'b1, '0, '0);
        step(1'b0, 1'b1, mk(10, 3, 11, 3), 1'b0, 1'b1, '0, '0);
        idle(3);
        // Writeback wakeup on port 1, then same-cycle bypass at dispatch.
        step(1'b0, 1'b1, mk(12, 4, 14, 4), 1'b0, 1'b1, '0, '0);
        idle(1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b10, wbp(12, 0));
        idle(2);
        step(1'b0, 1'b1, mk(13, 4, 15, 5), 1'b0, 1'b1, 2'b01, wbp(0, 13));
        idle(3);
        // Fill, attempt overflow, wake slot 3, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, mk(20 + i, 0, 40 + i, 8 + i), 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, mk(1, 1, 50, 20), 1'b1, 1'b1, '0, '0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b01, wbp(0, 23));
        idle(2);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b11, wbp(21, 20));
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b11, wbp(24, 22));
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b11, wbp(26, 25));
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b01, wbp(0, 27));
        idle(6);
        // Two ready entries around an unready one: oldest first.
        step(1'b0, 1'b1, mk(31, 0, 45, 21), 1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b1, mk(30, 0, 46, 22), 1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b1, mk(32, 0, 47, 23), 1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b11, wbp(32, 31));
        idle(2);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b01, wbp(0, 30));
        idle(3);
        // Flush with five entries and a dispatch in the same cycle.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, mk(50 + i, 0, 60, 24 + i), 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, mk(1, 1, 61, 29), 1'b1, 1'b1, '0, '0);
        idle(2);
        // Reset while ready instructions are in flight.
        step(1'b0, 1'b1, mk(2, 3, 62, 30), 1'b1, 1'b1, '0, '0);
        step(1'b0, 1'b1, mk(2, 3, 63, 31), 1'b1, 1'b1, '0, '0);
        mid_reset();
        idle(3);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            p = mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 100 + k);
            p.alu_en = 1'($urandom_range(0, 3) != 0);
            p.instr_valid = 1'($urandom_range(0, 7) != 0);
            if (k == 700) mid_reset();
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 6), p,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 WB_PORTS'($urandom), wbp($urandom_range(0, 15), $urandom_range(0, 15)));
        end
        for (int k = 0; k < 16; k += 2) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b11, wbp(k + 1, k));
        idle(12);
        chk("scoreboard_drained", 128'(fq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
